// File: rtl/led_reaction_game.sv
// LED reaction mini-game: lights one pseudo-random LED per round and scores the player's matching switch
// within a response window that can shrink as the score rises; tracks score, lives and the win/loss outcome.
module led_reaction_game #(
    parameter int N_LED         = 10,
    parameter int WIN_SCORE     = 3,
    parameter int WINDOW_CYC    = 100_000_000,
    parameter int LIVES         = 1,
    parameter int SPEEDUP       = 1,
    parameter int RESET_ON_MISS = 1
) (
    input  logic             MCLK,
    input  logic             RESET_N,
    input  logic             enable,
    input  logic [N_LED-1:0] SPDT,
    input  logic [3:0]       seed,
    output logic             done,
    output logic             win,
    output logic [3:0]       score,
    output logic [2:0]       lives_left,
    output logic [N_LED-1:0] LED,
    output logic             busy
);

    localparam int          TW       = (WINDOW_CYC > 1) ? $clog2(WINDOW_CYC) : 1;
    localparam int          IW       = $clog2(N_LED + 1);
    localparam logic [31:0] WIN_FULL = 32'(WINDOW_CYC);
    localparam logic [31:0] WIN_MIN  = WIN_FULL >> 3;

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_SHOW, S_WAIT, S_JUDGE, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [3:0]       score_q, score_d;
    logic [2:0]       lives_q, lives_d;
    logic [N_LED-1:0] led_q, led_d;
    logic [IW-1:0]    prev_idx_q, prev_idx_d;
    logic             hit_q, hit_d;
    logic             win_q, win_d;
    logic             en_q;

    logic [7:0]       mod_raw;
    logic [IW-1:0]    idx;
    logic [31:0]      win_shr;
    logic [31:0]      win_len;
    logic [TW-1:0]    win_last;
    logic             start;
    logic             fb;

    assign start = enable & ~en_q;
    assign fb    = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    // Target index; bumped by one when it would repeat the previous round's LED.
    always_comb begin
        mod_raw = lfsr_q[7:0] % 8'(N_LED);
        idx     = IW'(mod_raw);
        if (idx == prev_idx_q) begin
            idx = (idx == IW'(N_LED - 1)) ? '0 : idx + 1'b1;
        end
    end

    always_comb begin
        win_shr = WIN_FULL >> score_q;
        if (SPEEDUP != 0) begin
            win_len = (win_shr < WIN_MIN) ? WIN_MIN : win_shr;
        end else begin
            win_len = WIN_FULL;
        end
        win_last = TW'(win_len - 32'd1);
    end

    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= S_IDLE;
            lfsr_q     <= 16'hACE1;
            timer_q    <= '0;
            score_q    <= '0;
            lives_q    <= 3'(LIVES);
            led_q      <= '0;
            prev_idx_q <= IW'(N_LED);
            hit_q      <= 1'b0;
            win_q      <= 1'b0;
            en_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            timer_q    <= timer_d;
            score_q    <= score_d;
            lives_q    <= lives_d;
            led_q      <= led_d;
            prev_idx_q <= prev_idx_d;
            hit_q      <= hit_d;
            win_q      <= win_d;
            en_q       <= enable;
        end
    end

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        timer_d    = timer_q;
        score_d    = score_q;
        lives_d    = lives_q;
        led_d      = led_q;
        prev_idx_d = prev_idx_q;
        hit_d      = hit_q;
        win_d      = win_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    lfsr_d     = {seed, 12'hACE};
                    score_d    = '0;
                    lives_d    = 3'(LIVES);
                    win_d      = 1'b0;
                    prev_idx_d = IW'(N_LED);
                    led_d      = '0;
                    state_d    = S_ARM;
                end
            end
            S_ARM: begin
                led_d = '0;
                if (SPDT == '0) begin
                    state_d = S_SHOW;
                end
            end
            S_SHOW: begin
                led_d      = N_LED'(1) << idx;
                prev_idx_d = idx;
                timer_d    = '0;
                lfsr_d     = {lfsr_q[14:0], fb};
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                // led_q holds the target for the whole round; a stray switch outranks a match.
                timer_d = timer_q + 1'b1;
                if ((SPDT & ~led_q) != '0) begin
                    hit_d   = 1'b0;
                    state_d = S_JUDGE;
                end else if (SPDT == led_q) begin
                    hit_d   = 1'b1;
                    state_d = S_JUDGE;
                end else if (timer_q == win_last) begin
                    hit_d   = 1'b0;
                    state_d = S_JUDGE;
                end
            end
            S_JUDGE: begin
                led_d = '0;
                if (hit_q) begin
                    score_d = score_q + 4'd1;
                    if (score_q + 4'd1 == 4'(WIN_SCORE)) begin
                        win_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ARM;
                    end
                end else begin
                    lives_d = lives_q - 3'd1;
                    if (lives_q == 3'd1) begin
                        win_d   = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        if (RESET_ON_MISS != 0) begin
                            score_d = '0;
                        end
                        state_d = S_ARM;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign done       = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign win        = win_q;
    assign score      = score_q;
    assign lives_left = lives_q;
    assign LED        = led_q;

endmodule

// File: tb/tb_led_reaction_game.sv
// Directed bench for led_reaction_game: N_LED=10, WIN_SCORE=3, WINDOW_CYC=16, LIVES=2, SPEEDUP=1.
// With seed 4 the target LEDs of a game are, in order, 0x040, 0x080, 0x100, 0x020, 0x001.
module tb_led_reaction_game;

    logic       MCLK;
    logic       RESET_N;
    logic       enable;
    logic [9:0] SPDT;
    logic [3:0] seed;
    logic       done;
    logic       win;
    logic [3:0] score;
    logic [2:0] lives_left;
    logic [9:0] LED;
    logic       busy;

    int         checks;
    int         errors;
    logic [9:0] seen;
    logic [9:0] prev;
    logic [9:0] cover_bits;

    led_reaction_game #(
        .N_LED(10),
        .WIN_SCORE(3),
        .WINDOW_CYC(16),
        .LIVES(2),
        .SPEEDUP(1),
        .RESET_ON_MISS(1)
    ) dut (
        .MCLK(MCLK),
        .RESET_N(RESET_N),
        .enable(enable),
        .SPDT(SPDT),
        .seed(seed),
        .done(done),
        .win(win),
        .score(score),
        .lives_left(lives_left),
        .LED(LED),
        .busy(busy)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_led(output logic [9:0] led_seen);
        int n;
        n = 0;
        while (LED == '0 && n < 40) begin
            @(negedge MCLK);
            n++;
        end
        if (n >= 40) check("led_wait_timeout", 32'(n), 32'd0);
        led_seen = LED;
    endtask

    task automatic start_game(input logic [3:0] s);
        seed   = s;
        enable = 1'b1;
        @(negedge MCLK);
        enable = 1'b0;
    endtask

    task automatic hit_round(input string tag, input logic [9:0] exp_led, input int dly,
                             input logic [3:0] exp_score);
        logic [9:0] l;
        wait_led(l);
        check({tag, "_led"}, 32'(l), 32'(exp_led));
        repeat (dly) @(negedge MCLK);
        SPDT = exp_led;
        @(negedge MCLK);
        SPDT = '0;
        @(negedge MCLK);
        check({tag, "_score"}, 32'(score), 32'(exp_score));
    endtask

    task automatic timeout_round(input string tag, input logic [9:0] exp_led, input int wlen,
                                 input logic [2:0] lives_before, input logic [2:0] lives_after);
        logic [9:0] l;
        wait_led(l);
        check({tag, "_led"}, 32'(l), 32'(exp_led));
        repeat (wlen) @(negedge MCLK);
        check({tag, "_lives_hold"}, 32'(lives_left), 32'(lives_before));
        check({tag, "_led_hold"}, 32'(LED), 32'(exp_led));
        @(negedge MCLK);
        check({tag, "_lives"}, 32'(lives_left), 32'(lives_after));
        check({tag, "_led_off"}, 32'(LED), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        checks  = 0;
        errors  = 0;
        RESET_N = 1'b0;
        enable  = 1'b0;
        SPDT    = '0;
        seed    = 4'd4;
        repeat (3) @(negedge MCLK);
        check("rst_done", 32'(done), 32'd0);
        check("rst_win", 32'(win), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_score", 32'(score), 32'd0);
        check("rst_lives", 32'(lives_left), 32'd2);
        check("rst_led", 32'(LED), 32'd0);
        RESET_N = 1'b1;
        repeat (2) @(negedge MCLK);
        check("idle_busy", 32'(busy), 32'd0);

        // 1/2: start latency, then three hits to a win
        start_game(4'd4);
        check("t1_busy_arm", 32'(busy), 32'd1);
        @(negedge MCLK);
        check("t1_led_early", 32'(LED), 32'd0);
        @(negedge MCLK);
        check("t1_led", 32'(LED), 32'h040);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_score", 32'(score), 32'd0);
        check("t1_lives", 32'(lives_left), 32'd2);
        SPDT = 10'h040;
        @(negedge MCLK);
        SPDT = '0;
        @(negedge MCLK);
        check("t2_score1", 32'(score), 32'd1);
        enable = 1'b1;
        @(negedge MCLK);
        enable = 1'b0;
        hit_round("t2_r2", 10'h080, 2, 4'd2);
        hit_round("t2_r3", 10'h100, 1, 4'd3);
        check("t2_done", 32'(done), 32'd1);
        check("t2_win", 32'(win), 32'd1);
        check("t2_busy", 32'(busy), 32'd0);
        check("t2_led", 32'(LED), 32'd0);
        repeat (3) @(negedge MCLK);
        check("t2_done_hold", 32'(done), 32'd1);
        check("t2_score_hold", 32'(score), 32'd3);

        // 3: two full-window timeouts from DONE -> loss
        start_game(4'd4);
        check("t3_done_clr", 32'(done), 32'd0);
        check("t3_win_clr", 32'(win), 32'd0);
        timeout_round("t3_r1", 10'h040, 16, 3'd2, 3'd1);
        check("t3_score", 32'(score), 32'd0);
        timeout_round("t3_r2", 10'h080, 16, 3'd1, 3'd0);
        check("t3_done", 32'(done), 32'd1);
        check("t3_win", 32'(win), 32'd0);
        check("t3_busy", 32'(busy), 32'd0);

        // 4: extra switch is an immediate miss; window back to 16 after score reset
        start_game(4'd4);
        check("t4_lives_restore", 32'(lives_left), 32'd2);
        hit_round("t4_r1", 10'h040, 0, 4'd1);
        wait_led(seen);
        check("t4_r2_led", 32'(seen), 32'h080);
        SPDT = 10'h081;
        @(negedge MCLK);
        SPDT = '0;
        @(negedge MCLK);
        check("t4_r2_lives", 32'(lives_left), 32'd1);
        check("t4_r2_score", 32'(score), 32'd0);
        timeout_round("t4_r3", 10'h100, 16, 3'd1, 3'd0);
        check("t4_done", 32'(done), 32'd1);
        check("t4_win", 32'(win), 32'd0);

        // 5: window shrinks to 8 at score 1 and 4 at score 2; final loss keeps score
        start_game(4'd4);
        hit_round("t5_r1", 10'h040, 1, 4'd1);
        timeout_round("t5_r2", 10'h080, 8, 3'd2, 3'd1);
        check("t5_r2_score", 32'(score), 32'd0);
        hit_round("t5_r3", 10'h100, 0, 4'd1);
        hit_round("t5_r4", 10'h020, 2, 4'd2);
        timeout_round("t5_r5", 10'h001, 4, 3'd1, 3'd0);
        check("t5_done", 32'(done), 32'd1);
        check("t5_win", 32'(win), 32'd0);
        check("t5_score", 32'(score), 32'd2);

        // 6: stuck switch blocks ARM; async reset mid-WAIT
        SPDT = 10'h001;
        start_game(4'd4);
        repeat (20) @(negedge MCLK);
        check("t6_led_blocked", 32'(LED), 32'd0);
        check("t6_busy_blocked", 32'(busy), 32'd1);
        SPDT = '0;
        @(negedge MCLK);
        check("t6_led_early", 32'(LED), 32'd0);
        @(negedge MCLK);
        check("t6_led", 32'(LED), 32'h040);
        timeout_round("t6_r1", 10'h040, 16, 3'd2, 3'd1);
        hit_round("t6_r2", 10'h080, 0, 4'd1);
        wait_led(seen);
        check("t6_r3_led", 32'(seen), 32'h100);
        repeat (2) @(negedge MCLK);
        #2 RESET_N = 1'b0;
        #1;
        check("t6_rst_led", 32'(LED), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_done", 32'(done), 32'd0);
        check("t6_rst_win", 32'(win), 32'd0);
        check("t6_rst_score", 32'(score), 32'd0);
        check("t6_rst_lives", 32'(lives_left), 32'd2);
        @(negedge MCLK);
        RESET_N = 1'b1;
        repeat (3) @(negedge MCLK);
        check("t6_idle_busy", 32'(busy), 32'd0);
        check("t6_idle_led", 32'(LED), 32'd0);

        // 7: 204 rounds over many seeds: one-hot, no repeats, full index coverage
        cover_bits = '0;
        for (int g = 0; g < 34; g++) begin
            start_game(4'(g));
            prev = '0;
            for (int r = 0; r < 6; r++) begin
                wait_led(seen);
                check("t7_onehot", 32'($countones(seen)), 32'd1);
                check("t7_norepeat", 32'(seen == prev), 32'd0);
                cover_bits = cover_bits | seen;
                prev = seen;
                if (r == 2 || r == 5) SPDT = seen | ((seen == 10'h001) ? 10'h002 : 10'h001);
                else SPDT = seen;
                @(negedge MCLK);
                SPDT = '0;
                @(negedge MCLK);
            end
            check("t7_done", 32'(done), 32'd1);
            check("t7_win", 32'(win), 32'd0);
        end
        check("t7_coverage", 32'(cover_bits), 32'h3FF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
